ones_cnt: RTL and testbench

// - Population counter: reports how many bits of vector A are set.
// - Used by the prefetcher to count valid/hit flags across a slot vector.
// - Combinational count, plus a registered copy and a full-vector flag for timing-critical consumers.

---
 rtl/ones_cnt_pkg.sv | 10 +
 rtl/ones_cnt_add.sv | 12 +
 rtl/ones_cnt.sv | 71 +++++++
 tb/tb_ones_cnt.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ones_cnt_pkg.sv
// Shared constants and helpers for the ones_cnt population counter.
package ones_cnt_pkg;

    localparam int LOG_VEC_SIZE_DEF = 3;

    function automatic int vec_size(input int log_size);
        return 32'd1 << log_size;
    endfunction

endpackage

// File: rtl/ones_cnt_add.sv
// One node of the popcount adder tree: W-bit + W-bit unsigned sum with carry out.
module ones_cnt_add #(
    parameter int W = 1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W:0]   sum_o
);

    assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/ones_cnt.sv
// Population counter over A: balanced adder tree for the combinational count,
// plus registered copies of the count and the full-vector flag.
module ones_cnt
    import ones_cnt_pkg::*;
#(
    parameter  int LOG_VEC_SIZE = LOG_VEC_SIZE_DEF,
    localparam int VEC_SIZE     = vec_size(LOG_VEC_SIZE)
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic [0:VEC_SIZE-1]     A,
    output logic [0:LOG_VEC_SIZE-1] ones,
    output logic                    allOnes,
    output logic [0:LOG_VEC_SIZE-1] onesReg,
    output logic                    allOnesReg
);

    logic [LOG_VEC_SIZE:0]   total_s;
    logic [LOG_VEC_SIZE-1:0] ones_d;
    logic                    all_ones_d;
    logic [LOG_VEC_SIZE-1:0] ones_q;
    logic                    all_ones_q;

    // Level lv adds pairs of (lv+1)-bit partial counts into (lv+2)-bit counts.
    for (genvar lv = 0; lv < LOG_VEC_SIZE; lv++) begin : lvl_g
        localparam int NODES = VEC_SIZE >> (lv + 1);
        logic [lv+1:0] sum_s [NODES];

        for (genvar n = 0; n < NODES; n++) begin : node_g
            logic [lv:0] a_s;
            logic [lv:0] b_s;

            if (lv == 0) begin : leaf_g
                assign a_s = A[2*n];
                assign b_s = A[2*n+1];
            end else begin : inner_g
                assign a_s = lvl_g[lv-1].sum_s[2*n];
                assign b_s = lvl_g[lv-1].sum_s[2*n+1];
            end

            ones_cnt_add #(.W(lv + 1)) u_add (
                .a_i   (a_s),
                .b_i   (b_s),
                .sum_o (sum_s[n])
            );
        end
    end

    // The tree root is one bit wider than ones; its MSB is set only for a full vector.
    assign total_s    = lvl_g[LOG_VEC_SIZE-1].sum_s[0];
    assign ones_d     = total_s[LOG_VEC_SIZE-1:0];
    assign all_ones_d = total_s[LOG_VEC_SIZE];

    assign ones       = ones_d;
    assign allOnes    = all_ones_d;

    // Registered copy of the count and full flag for timing-critical consumers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ones_q     <= '0;
            all_ones_q <= 1'b0;
        end else begin
            ones_q     <= ones_d;
            all_ones_q <= all_ones_d;
        end
    end

    assign onesReg    = ones_q;
    assign allOnesReg = all_ones_q;

endmodule

// File: tb/tb_ones_cnt.sv
// Self-checking bench for ones_cnt at LOG_VEC_SIZE 3, 2 and 4.
module tb_ones_cnt;

    logic clk = 1'b0;
    logic resetN;

    logic [0:7]  a8;
    logic [0:2]  ones8,  onesreg8;
    logic        all8,   allreg8;
    logic [0:3]  a4;
    logic [0:1]  ones4,  onesreg4;
    logic        all4,   allreg4;
    logic [0:15] a16;
    logic [0:3]  ones16, onesreg16;
    logic        all16,  allreg16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ones_cnt #(.LOG_VEC_SIZE(3)) dut (
        .clk(clk), .resetN(resetN), .A(a8), .ones(ones8), .allOnes(all8),
        .onesReg(onesreg8), .allOnesReg(allreg8)
    );
    ones_cnt #(.LOG_VEC_SIZE(2)) dut2 (
        .clk(clk), .resetN(resetN), .A(a4), .ones(ones4), .allOnes(all4),
        .onesReg(onesreg4), .allOnesReg(allreg4)
    );
    ones_cnt #(.LOG_VEC_SIZE(4)) dut4 (
        .clk(clk), .resetN(resetN), .A(a16), .ones(ones16), .allOnes(all16),
        .onesReg(onesreg16), .allOnesReg(allreg16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: count set bits, wrap modulo the vector width.
    function automatic logic [31:0] ref_ones(input logic [31:0] v, input int lg);
        int c;
        c = $countones(v);
        return 32'(c % (1 << lg));
    endfunction

    function automatic logic [31:0] ref_all(input logic [31:0] v, input int lg);
        return ($countones(v) == (1 << lg)) ? 32'd1 : 32'd0;
    endfunction

    task automatic comb8(input string tag, input logic [0:7] v, input int exp_ones, input int exp_all);
        a8 = v;
        #2;
        check({tag, "_ones"}, 32'(ones8), 32'(exp_ones));
        check({tag, "_all"},  32'(all8),  32'(exp_all));
    endtask

    initial begin
        logic [31:0] p_ones8, p_all8, p_ones4, p_all4, p_ones16, p_all16;

        resetN = 1'b0;
        a8  = 8'h00;
        a4  = 4'h0;
        a16 = 16'h0000;
        #1;
        check("rst_onesreg8",  32'(onesreg8),  32'd0);
        check("rst_allreg8",   32'(allreg8),   32'd0);
        check("rst_onesreg4",  32'(onesreg4),  32'd0);
        check("rst_onesreg16", 32'(onesreg16), 32'd0);

        // Combinational path is live while reset is held; registers stay cleared.
        @(negedge clk);
        comb8("in_reset", 8'b1001_1100, 4, 0);
        @(posedge clk); #1;
        check("held_onesreg8", 32'(onesreg8), 32'd0);
        @(negedge clk);
        resetN = 1'b1;

        @(negedge clk); comb8("zero",  8'b0000_0000, 0, 0);
        @(negedge clk); comb8("one",   8'b0100_0000, 1, 0);
        @(negedge clk); comb8("four",  8'b1001_1100, 4, 0);
        @(negedge clk); comb8("five",  8'b1011_1010, 5, 0);
        @(negedge clk); comb8("seven", 8'b1111_1110, 7, 0);
        @(negedge clk); comb8("full",  8'b1111_1111, 0, 1);
        @(posedge clk); #1;
        check("full_onesreg", 32'(onesreg8), 32'd0);
        check("full_allreg",  32'(allreg8),  32'd1);

        // Registered path: exactly one cycle of latency.
        @(negedge clk);
        a8 = 8'b1011_1010;
        #2;
        check("lat_old_onesreg", 32'(onesreg8), 32'd0);
        check("lat_old_allreg",  32'(allreg8),  32'd1);
        @(posedge clk); #1;
        check("lat_new_onesreg", 32'(onesreg8), 32'd5);
        check("lat_new_allreg",  32'(allreg8),  32'd0);
        a8 = 8'h00;
        #2;
        check("hold_onesreg", 32'(onesreg8), 32'd5);
        @(posedge clk); #1;
        check("next_onesreg", 32'(onesreg8), 32'd0);

        // Asynchronous reset between edges, held across edges, then release.
        @(negedge clk);
        a8 = 8'b1011_1010;
        @(posedge clk); #1;
        check("pre_rst_onesreg", 32'(onesreg8), 32'd5);
        #2;
        resetN = 1'b0;
        #1;
        check("async_onesreg", 32'(onesreg8), 32'd0);
        check("async_allreg",  32'(allreg8),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_onesreg", 32'(onesreg8), 32'd0);
        check("rst_hold_ones",    32'(ones8),    32'd5);
        @(negedge clk);
        a8 = 8'b1001_1100;
        resetN = 1'b1;
        #1;
        check("release_onesreg", 32'(onesreg8), 32'd0);
        @(posedge clk); #1;
        check("first_cap_onesreg", 32'(onesreg8), 32'd4);
        check("first_cap_allreg",  32'(allreg8),   32'd0);

        // Sweep: exhaustive for widths 8 and 4, randomized for width 16.
        p_ones8  = ref_ones(32'(a8), 3);   p_all8  = ref_all(32'(a8), 3);
        p_ones4  = ref_ones(32'(a4), 2);   p_all4  = ref_all(32'(a4), 2);
        p_ones16 = ref_ones(32'(a16), 4);  p_all16 = ref_all(32'(a16), 4);
        for (int v = 0; v < 256; v++) begin
            @(negedge clk);
            check("sw_onesreg8",  32'(onesreg8),  p_ones8);
            check("sw_allreg8",   32'(allreg8),   p_all8);
            check("sw_onesreg4",  32'(onesreg4),  p_ones4);
            check("sw_allreg4",   32'(allreg4),   p_all4);
            check("sw_onesreg16", 32'(onesreg16), p_ones16);
            check("sw_allreg16",  32'(allreg16),  p_all16);
            a8  = 8'(v);
            a4  = 4'(v);
            a16 = (v == 255 || v == 100) ? 16'hFFFF : 16'($urandom);
            #1;
            p_ones8  = ref_ones(32'(a8), 3);   p_all8  = ref_all(32'(a8), 3);
            p_ones4  = ref_ones(32'(a4), 2);   p_all4  = ref_all(32'(a4), 2);
            p_ones16 = ref_ones(32'(a16), 4);  p_all16 = ref_all(32'(a16), 4);
            check("sw_ones8",  32'(ones8),  p_ones8);
            check("sw_all8",   32'(all8),   p_all8);
            check("sw_ones4",  32'(ones4),  p_ones4);
            check("sw_all4",   32'(all4),   p_all4);
            check("sw_ones16", 32'(ones16), p_ones16);
            check("sw_all16",  32'(all16),  p_all16);
        end
        @(negedge clk);
        check("end_onesreg8",  32'(onesreg8),  p_ones8);
        check("end_allreg8",   32'(allreg8),   p_all8);
        check("end_onesreg16", 32'(onesreg16), p_ones16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
